// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with a busy scoreboard.
//
// Two write ports (port 0 = ALU writeback, port 1 = load writeback) and
// read_ports combinational read ports. Register 0 always reads as zero and
// can never be written or marked busy. A per-register busy flag is set when
// an instruction issues with that register as its destination, and cleared
// when either write port writes the register.
//
// Ports:
//   clock        - sole clock, rising edge
//   reset_n      - synchronous active-low reset
//   read_addr    - packed read indices, port k at [k*address_width +: address_width]
//   read_data    - packed read values,  port k at [k*data_width +: data_width]
//   read_busy    - busy flag of each read port's register
//   we0/wa0/wd0  - write port 0
//   we1/wa1/wd1  - write port 1 (wins over port 0 on the same address)
//   issue_en     - mark issue_addr as having an outstanding producer
//   issue_addr   - destination register being issued
//   busy_count   - registered population count of the busy vector
module reg_file_mp #(
    parameter int unsigned             data_width    = 32,
    parameter int unsigned             address_width = 5,
    parameter int unsigned             read_ports    = 2,
    parameter int unsigned             BYPASS        = 1,
    parameter logic [data_width-1:0]   SP            = '0,
    parameter int unsigned             SP_INDEX      = 29
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [read_ports*address_width-1:0] read_addr,
    output logic [read_ports*data_width-1:0]    read_data,
    output logic [read_ports-1:0]               read_busy,
    input  logic                                we0,
    input  logic [address_width-1:0]            wa0,
    input  logic [data_width-1:0]               wd0,
    input  logic                                we1,
    input  logic [address_width-1:0]            wa1,
    input  logic [data_width-1:0]               wd1,
    input  logic                                issue_en,
    input  logic [address_width-1:0]            issue_addr,
    output logic [address_width:0]              busy_count
);

    localparam int unsigned DEPTH = 1 << address_width;

    logic [data_width-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_next;
    logic [address_width:0] busy_count_next;

    logic wr0_act;
    logic wr1_act;
    logic iss_act;

    assign wr0_act = we0 && (wa0 != '0);
    assign wr1_act = we1 && (wa1 != '0);
    assign iss_act = issue_en && (issue_addr != '0);

    // Clears are applied before the set so that an issue to a register being
    // written in the same cycle leaves it busy.
    always_comb begin
        busy_next = busy;
        if (wr0_act) busy_next[wa0] = 1'b0;
        if (wr1_act) busy_next[wa1] = 1'b0;
        if (iss_act) busy_next[issue_addr] = 1'b1;
    end

    always_comb begin
        busy_count_next = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            busy_count_next = busy_count_next + {{address_width{1'b0}}, busy_next[i]};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= (i == SP_INDEX) ? SP : '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr0_act) mem[wa0] <= wd0;
            if (wr1_act) mem[wa1] <= wd1;
            busy       <= busy_next;
            busy_count <= busy_count_next;
        end
    end

    always_comb begin
        logic [address_width-1:0] ra;
        logic                     hit0;
        logic                     hit1;
        logic                     hit_iss;
        read_data = '0;
        read_busy = '0;
        for (int unsigned k = 0; k < read_ports; k++) begin
            ra      = read_addr[k*address_width +: address_width];
            hit0    = wr0_act && (wa0 == ra);
            hit1    = wr1_act && (wa1 == ra);
            hit_iss = iss_act && (issue_addr == ra);
            if (ra != '0) begin
                read_data[k*data_width +: data_width] = mem[ra];
                read_busy[k] = busy[ra];
                if (BYPASS != 0) begin
                    if (hit1)
                        read_data[k*data_width +: data_width] = wd1;
                    else if (hit0)
                        read_data[k*data_width +: data_width] = wd0;
                    // A same-cycle write retires the producer unless a new
                    // issue claims the register again in that cycle.
                    if ((hit0 || hit1) && !hit_iss)
                        read_busy[k] = 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL provide parameter data_width, default 32, register width in bits.
REQ-002 SHALL provide parameter address_width, default 5, register index width; depth = 2**address_width.
REQ-003 SHALL provide parameter read_ports, default 2, number of read ports (1..4).
REQ-004 SHALL provide parameter BYPASS, default 1, where 1 forwards same-cycle write data to the read ports and 0 returns stored contents only.
REQ-005 SHALL provide parameter SP, default 0, reset value of the stack-pointer register.
REQ-006 SHALL provide parameter SP_INDEX, default 29, index of the stack-pointer register.
REQ-007 SHALL have port clock, input, 1 bit, the sole clock; all state updates on its rising edge.
REQ-008 SHALL have port reset_n, input, 1 bit, reset that is synchronous and active-low.
REQ-009 SHALL have port read_addr, input, read_ports*address_width bits, packed read indices, with port k at bits [k*address_width +: address_width].
REQ-010 SHALL have port read_data, output, read_ports*data_width bits, packed read values, with port k at bits [k*data_width +: data_width].
REQ-011 SHALL have port read_busy, output, read_ports bits, scoreboard busy flag for each read port's register.
REQ-012 SHALL have ports we0 (input, 1), wa0 (input, address_width) and wd0 (input, data_width), forming write port 0 (ALU writeback).
REQ-013 SHALL have ports we1 (input, 1), wa1 (input, address_width) and wd1 (input, data_width), forming write port 1 (load writeback).
REQ-014 SHALL have ports issue_en (input, 1) and issue_addr (input, address_width), which mark a destination register as having an outstanding producer.
REQ-015 SHALL have port busy_count, output, address_width+1 bits, number of registers currently marked busy.

Function
REQ-016 SHALL make reads combinational, with zero-cycle latency from read_addr to read_data and read_busy.
REQ-017 SHALL return 0 on read_data and 0 on read_busy for any read of register 0, regardless of writes.
REQ-018 SHALL ignore writes to register 0 on either write port, and SHALL never set busy for register 0.
REQ-019 SHALL update mem[wa0] <= wd0 on the rising edge when we0=1 and wa0!=0; port 1 SHALL behave likewise with we1, wa1 and wd1.
REQ-020 SHALL let port 1 win when both ports write the same nonzero address in one cycle, storing wd1.
REQ-021 SHALL, when BYPASS=1 and a read address matches an active nonzero write address in the same cycle, return that write's data, with wd1 taking priority over wd0.
REQ-022 SHALL, when BYPASS=0, return the pre-edge stored value for the case in REQ-021.
REQ-023 SHALL set busy[issue_addr] at the rising edge when issue_en=1 and issue_addr!=0.
REQ-024 SHALL clear busy[wa] at the rising edge on any active nonzero write on either port.
REQ-025 SHALL let set win when an issue and a write target the same address in the same cycle, so busy ends at 1.
REQ-026 SHALL not change busy when an issue targets a register that is already busy.
REQ-027 SHALL not set busy on a write to a non-busy register; the data is still stored.
REQ-028 SHALL, when BYPASS=1, report read_busy=0 if the register is being cleared by a write in the same cycle and no same-cycle issue targets it; when BYPASS=0, read_busy SHALL report the registered flag.
REQ-029 SHALL make busy_count a registered output equal to the population count of the busy vector after each edge.
REQ-030 SHALL update busy_count by a net change of +1, 0, -1 or -2 per cycle, and it SHALL never exceed 2**address_width-1.

Reset
REQ-031 SHALL, on any rising edge with reset_n=0, set every register to 0 except mem[SP_INDEX]=SP, clear busy, and set busy_count=0.
REQ-032 SHALL give reset priority over all writes and issues in the same cycle; those writes and issues SHALL be discarded.
REQ-033 SHALL, when reset is asserted mid-operation, discard all outstanding busy marks; normal operation SHALL resume on the first edge with reset_n=1.
REQ-034 SHALL, after reset with no writes, return 0 on all reads except SP_INDEX, which SHALL return SP.

Verification
REQ-035 SHALL be covered by a reset scenario: with SP=32'h0000_1000, pulse reset_n low for 1 edge, then read address 29 -> 32'h1000, read address 5 -> 0, busy_count=0.
REQ-036 SHALL be covered by a dual-write collision scenario: we0=we1=1, wa0=wa1=7, wd0=32'hAAAA, wd1=32'h5555 -> next cycle, read 7 -> 32'h5555.
REQ-037 SHALL be covered by a bypass scenario: with BYPASS=1, we0=1, wa0=3, wd0=32'h1234, read_addr port1=3 in the same cycle -> read_data port1=32'h1234; with BYPASS=0 the same stimulus -> the old value.
REQ-038 SHALL be covered by a scoreboard scenario: issue_en to 4, then 9 -> busy_count=2; write via port 1 to 4 -> busy_count=1 and read_busy(4)=0; issue and write to 9 in the same cycle -> busy(9)=1.
REQ-039 SHALL be covered by a register-0 scenario: we0=1, wa0=0, wd0=32'hFFFF_FFFF and issue_en with issue_addr=0 -> read 0 returns 0, busy_count unchanged.
REQ-040 SHALL be covered by a reset-with-write scenario: reset_n=0 with we0=1 to register 2 in the same cycle -> register 2 reads 0 after the edge.
